// File: rtl/restock_arbiter.sv
// Two-channel restock arbiter: kitchen and refrigerator channels each grant one of two requesters.
// Optional WAIT timeout with req_err pulses is enabled by defining RESTOCK_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | channel free, arbitrating matching requests
// WAIT  | owner latched, waiting for slave ready (or zero-quantity skip / timeout)
// SEND  | one-cycle transfer strobe and ack to owner
module restock_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  req_valid,
   input  logic [1:0]  req_dest,
   input  logic [1:0]  req_product,
   input  logic [11:0] req_number,
   output logic [1:0]  req_ack,
   output logic [1:0]  req_err,
   input  logic        ready_kitch,
   input  logic        ready_refri,
   output logic        valid_kitch,
   output logic        valid_refri,
   output logic        product_kitch,
   output logic        product_refri,
   output logic [5:0]  number_kitch,
   output logic [5:0]  number_refri,
   output logic        busy_kitch,
   output logic        busy_refri
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      SEND = 2'd2
   } state_t;

   // Channel index: 0 = kitchen (dest 0), 1 = refrigerator (dest 1)
   state_t      state_q [2];
   state_t      state_d [2];
   logic [1:0]  owner_q, owner_d;
   logic [1:0]  ptr_q, ptr_d;
   logic [1:0]  prod_q, prod_d;
   logic [5:0]  num_q [2];
   logic [5:0]  num_d [2];

   logic [1:0]  ack_q, ack_d;
   logic [1:0]  valid_q, valid_d;
   logic [1:0]  prod_o_q, prod_o_d;
   logic [1:0]  busy_q, busy_d;
   logic [5:0]  num_o_q [2];
   logic [5:0]  num_o_d [2];

`ifdef RESTOCK_ARB_TIMEOUT_EN
   logic [1:0]  err_q, err_d;
   logic [3:0]  cnt_q [2];
   logic [3:0]  cnt_d [2];
`endif

   logic [1:0]  ready;
   logic [1:0]  rel_mask;
   logic [1:0]  match [2];
   logic [1:0]  win;

   assign ready = {ready_refri, ready_kitch};

   function automatic logic [5:0] clamp_num(input logic [5:0] n);
      return (n > 6'd50) ? 6'd50 : n;
   endfunction

   always_comb begin
      // A requester whose ack/err is high this cycle is still presenting its
      // finished request; it must not be granted again.
`ifdef RESTOCK_ARB_TIMEOUT_EN
      rel_mask = ack_q | err_q;
      err_d    = '0;
`else
      rel_mask = ack_q;
`endif
      ack_d    = '0;
      valid_d  = '0;
      prod_o_d = '0;
      owner_d  = owner_q;
      ptr_d    = ptr_q;
      prod_d   = prod_q;
      win      = '0;
      for (int c = 0; c < 2; c++) begin
         state_d[c]  = state_q[c];
         num_d[c]    = num_q[c];
         num_o_d[c]  = '0;
`ifdef RESTOCK_ARB_TIMEOUT_EN
         cnt_d[c]    = cnt_q[c];
`endif
         match[c] = req_valid & ~rel_mask & ((c == 0) ? ~req_dest : req_dest);
         win[c]   = (match[c] == 2'b11) ? ptr_q[c] : match[c][1];

         case (state_q[c])
            IDLE: begin
               if (|match[c]) begin
                  owner_d[c] = win[c];
                  prod_d[c]  = req_product[win[c]];
                  num_d[c]   = clamp_num(win[c] ? req_number[11:6] : req_number[5:0]);
                  state_d[c] = WAIT;
`ifdef RESTOCK_ARB_TIMEOUT_EN
                  cnt_d[c]   = '0;
`endif
               end
            end
            WAIT: begin
               if (num_q[c] == 6'd0) begin
                  state_d[c]         = IDLE;
                  ack_d[owner_q[c]]  = 1'b1;
                  ptr_d[c]           = ~owner_q[c];
               end else if (ready[c]) begin
                  state_d[c]         = SEND;
                  valid_d[c]         = 1'b1;
                  prod_o_d[c]        = prod_q[c];
                  num_o_d[c]         = num_q[c];
                  ack_d[owner_q[c]]  = 1'b1;
               end
`ifdef RESTOCK_ARB_TIMEOUT_EN
               else if (cnt_q[c] == 4'd14) begin
                  state_d[c]         = IDLE;
                  err_d[owner_q[c]]  = 1'b1;
                  ptr_d[c]           = ~owner_q[c];
               end else begin
                  cnt_d[c]           = cnt_q[c] + 4'd1;
               end
`endif
            end
            SEND: begin
               state_d[c] = IDLE;
               ptr_d[c]   = ~owner_q[c];
            end
            default: state_d[c] = IDLE;
         endcase
      end
      busy_d[0] = (state_d[0] != IDLE);
      busy_d[1] = (state_d[1] != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_q  <= '0;
         ptr_q    <= '0;
         prod_q   <= '0;
         ack_q    <= '0;
         valid_q  <= '0;
         prod_o_q <= '0;
         busy_q   <= '0;
         for (int c = 0; c < 2; c++) begin
            state_q[c] <= IDLE;
            num_q[c]   <= '0;
            num_o_q[c] <= '0;
         end
      end else begin
         owner_q  <= owner_d;
         ptr_q    <= ptr_d;
         prod_q   <= prod_d;
         ack_q    <= ack_d;
         valid_q  <= valid_d;
         prod_o_q <= prod_o_d;
         busy_q   <= busy_d;
         for (int c = 0; c < 2; c++) begin
            state_q[c] <= state_d[c];
            num_q[c]   <= num_d[c];
            num_o_q[c] <= num_o_d[c];
         end
      end
   end

`ifdef RESTOCK_ARB_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= '0;
         for (int c = 0; c < 2; c++) cnt_q[c] <= '0;
      end else begin
         err_q <= err_d;
         for (int c = 0; c < 2; c++) cnt_q[c] <= cnt_d[c];
      end
   end

   assign req_err = err_q;
`else
   assign req_err = 2'b00;
`endif

   assign req_ack       = ack_q;
   assign valid_kitch   = valid_q[0];
   assign valid_refri   = valid_q[1];
   assign product_kitch = prod_o_q[0];
   assign product_refri = prod_o_q[1];
   assign number_kitch  = num_o_q[0];
   assign number_refri  = num_o_q[1];
   assign busy_kitch    = busy_q[0];
   assign busy_refri    = busy_q[1];

endmodule

// File: tb/tb_restock_arbiter.sv
// Directed bench for restock_arbiter; inputs driven and outputs sampled 1 time unit after the rising edge.
module tb_restock_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid, req_dest, req_product;
   logic [11:0] req_number;
   logic [1:0]  req_ack, req_err;
   logic        ready_kitch, ready_refri;
   logic        valid_kitch, valid_refri;
   logic        product_kitch, product_refri;
   logic [5:0]  number_kitch, number_refri;
   logic        busy_kitch, busy_refri;

   int errors = 0;
   int checks = 0;

   restock_arbiter dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_dest(req_dest), .req_product(req_product),
      .req_number(req_number), .req_ack(req_ack), .req_err(req_err),
      .ready_kitch(ready_kitch), .ready_refri(ready_refri),
      .valid_kitch(valid_kitch), .valid_refri(valid_refri),
      .product_kitch(product_kitch), .product_refri(product_refri),
      .number_kitch(number_kitch), .number_refri(number_refri),
      .busy_kitch(busy_kitch), .busy_refri(busy_refri)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] v, input logic [1:0] d, input logic [1:0] p,
                        input logic [5:0] n0, input logic [5:0] n1);
      req_valid   = v;
      req_dest    = d;
      req_product = p;
      req_number  = {n1, n0};
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ack"},   {14'd0, req_ack}, 16'd0);
      check({tag, "_err"},   {14'd0, req_err}, 16'd0);
      check({tag, "_valid"}, {14'd0, valid_refri, valid_kitch}, 16'd0);
      check({tag, "_busy"},  {14'd0, busy_refri, busy_kitch}, 16'd0);
      check({tag, "_data"},  {2'd0, product_refri, product_kitch, number_refri, number_kitch}, 16'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      drive(2'b00, 2'b00, 2'b00, 6'd0, 6'd0);
      ready_kitch = 1'b0;
      ready_refri = 1'b0;
      #1;
      check_all_zero("reset");
      step();
      step();
      rst = 1'b0;

      // Single kitchen request, ready already high: result two cycles later
      ready_kitch = 1'b1;
      drive(2'b01, 2'b00, 2'b01, 6'd20, 6'd0);
      step();
      check("t1_busy_wait", {15'd0, busy_kitch}, 16'd1);
      check("t1_valid_wait", {15'd0, valid_kitch}, 16'd0);
      step();
      check("t1_valid", {15'd0, valid_kitch}, 16'd1);
      check("t1_product", {15'd0, product_kitch}, 16'd1);
      check("t1_number", {10'd0, number_kitch}, 16'd20);
      check("t1_ack", {14'd0, req_ack}, 16'b01);
      step();
      drive(2'b00, 2'b00, 2'b00, 6'd0, 6'd0);
      check("t1_after_valid", {15'd0, valid_kitch}, 16'd0);
      check("t1_after_num", {10'd0, number_kitch}, 16'd0);
      check("t1_after_ack", {14'd0, req_ack}, 16'd0);
      check("t1_after_busy", {15'd0, busy_kitch}, 16'd0);

      // Refrigerator contention and pointer rotation
      ready_refri = 1'b1;
      drive(2'b11, 2'b11, 2'b10, 6'd5, 6'd7);
      step();
      step();
      check("t2_first_valid", {15'd0, valid_refri}, 16'd1);
      check("t2_first_num", {10'd0, number_refri}, 16'd5);
      check("t2_first_prod", {15'd0, product_refri}, 16'd0);
      check("t2_first_ack", {14'd0, req_ack}, 16'b01);
      step();
      drive(2'b11, 2'b11, 2'b10, 6'd9, 6'd7);
      check("t2_idle_valid", {15'd0, valid_refri}, 16'd0);
      step();
      step();
      check("t2_second_num", {10'd0, number_refri}, 16'd7);
      check("t2_second_prod", {15'd0, product_refri}, 16'd1);
      check("t2_second_ack", {14'd0, req_ack}, 16'b10);
      step();
      drive(2'b11, 2'b11, 2'b10, 6'd9, 6'd8);
      step();
      step();
      check("t2_third_num", {10'd0, number_refri}, 16'd9);
      check("t2_third_ack", {14'd0, req_ack}, 16'b01);
      step();
      drive(2'b00, 2'b00, 2'b00, 6'd0, 6'd0);
      step();
      step();
      step();

      // Clamp on kitchen, zero-quantity skip on refrigerator
      drive(2'b11, 2'b10, 2'b00, 6'd63, 6'd0);
      step();
      check("t3_busy_both", {14'd0, busy_refri, busy_kitch}, 16'b11);
      step();
      check("t3_num_clamp", {10'd0, number_kitch}, 16'd50);
      check("t3_valid_kitch", {15'd0, valid_kitch}, 16'd1);
      check("t3_ack_both", {14'd0, req_ack}, 16'b11);
      check("t3_valid_refri", {15'd0, valid_refri}, 16'd0);
      check("t3_busy_refri", {15'd0, busy_refri}, 16'd0);
      step();
      drive(2'b00, 2'b00, 2'b00, 6'd0, 6'd0);
      check("t3_no_regrant", {14'd0, busy_refri, busy_kitch}, 16'b00);
      check("t3_valid_refri_late", {15'd0, valid_refri}, 16'd0);
      step();

      // Kitchen ready low for 5 cycles
      ready_kitch = 1'b0;
      drive(2'b01, 2'b00, 2'b00, 6'd3, 6'd0);
      for (int i = 1; i <= 5; i++) begin
         step();
         check($sformatf("t4_busy_%0d", i), {15'd0, busy_kitch}, 16'd1);
         check($sformatf("t4_novalid_%0d", i), {15'd0, valid_kitch}, 16'd0);
      end
      ready_kitch = 1'b1;
      step();
      check("t4_valid", {15'd0, valid_kitch}, 16'd1);
      check("t4_busy_send", {15'd0, busy_kitch}, 16'd1);
      check("t4_num", {10'd0, number_kitch}, 16'd3);
      check("t4_ack", {14'd0, req_ack}, 16'b01);
      step();
      drive(2'b00, 2'b00, 2'b00, 6'd0, 6'd0);
      check("t4_single_pulse", {15'd0, valid_kitch}, 16'd0);
      step();

      // Refrigerator starved of ready
      ready_refri = 1'b0;
      drive(2'b10, 2'b10, 2'b00, 6'd0, 6'd4);
      for (int i = 1; i <= 15; i++) begin
         step();
         check($sformatf("t5_busy_%0d", i), {15'd0, busy_refri}, 16'd1);
         check($sformatf("t5_noerr_%0d", i), {14'd0, req_err}, 16'd0);
      end
      step();
`ifdef RESTOCK_ARB_TIMEOUT_EN
      check("t5_err", {14'd0, req_err}, 16'b10);
      check("t5_busy_after", {15'd0, busy_refri}, 16'd0);
      check("t5_no_ack", {14'd0, req_ack}, 16'd0);
`else
      check("t5_err_tied", {14'd0, req_err}, 16'd0);
      check("t5_busy_stays", {15'd0, busy_refri}, 16'd1);
`endif
      check("t5_no_valid", {15'd0, valid_refri}, 16'd0);
      step();
      drive(2'b00, 2'b00, 2'b00, 6'd0, 6'd0);
      rst = 1'b1;
      #1;
      check_all_zero("t5_reset");
      step();
      rst = 1'b0;

      // Reset while kitchen waits, then re-issue
      ready_kitch = 1'b0;
      drive(2'b01, 2'b00, 2'b01, 6'd12, 6'd0);
      step();
      step();
      check("t6_busy_wait", {15'd0, busy_kitch}, 16'd1);
      rst = 1'b1;
      #1;
      check_all_zero("t6_abort");
      drive(2'b00, 2'b00, 2'b00, 6'd0, 6'd0);
      ready_kitch = 1'b1;
      step();
      rst = 1'b0;
      step();
      check("t6_no_ack", {14'd0, req_ack}, 16'd0);
      check("t6_no_valid", {15'd0, valid_kitch}, 16'd0);
      drive(2'b01, 2'b00, 2'b01, 6'd12, 6'd0);
      step();
      check("t6_reissue_busy", {15'd0, busy_kitch}, 16'd1);
      step();
      check("t6_reissue_valid", {15'd0, valid_kitch}, 16'd1);
      check("t6_reissue_num", {10'd0, number_kitch}, 16'd12);
      check("t6_reissue_prod", {15'd0, product_kitch}, 16'd1);
      check("t6_reissue_ack", {14'd0, req_ack}, 16'b01);
      step();
      drive(2'b00, 2'b00, 2'b00, 6'd0, 6'd0);
      step();
      check_all_zero("t6_end");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/restock_arbiter.md
RESTOCK_ARBITER -- requirements
Module: restock_arbiter

Interface
REQ-001 SHALL have ports (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  2  restock request per shop front-end (bit i = requester i)
- req_dest  in  2  per-requester destination: 0 = kitchen, 1 = refrigerator
- req_product  in  2  per-requester product address bit
- req_number  in  12  per-requester quantity, 6 bits each, [5:0] = requester 0
- req_ack  out  2  one-cycle completion pulse per requester
- req_err  out  2  one-cycle timeout pulse per requester
- ready_kitch, ready_refri  in  1  slave ready
- valid_kitch, valid_refri  out  1  one-cycle transfer strobe
- product_kitch, product_refri  out  1  product address
- number_kitch, number_refri  out  6  quantity
- busy_kitch, busy_refri  out  1  channel FSM not IDLE

REQ-002 SHALL use the fixed reset scheme: one clock, rst asynchronous active-high; all outputs registered.

Function
REQ-003 SHALL run two independent channel FSMs (kitchen, refrigerator), each with states IDLE, WAIT, SEND.
REQ-004 A requester SHALL hold req_valid/dest/product/number stable from assertion through the cycle its req_ack or req_err is high; the block need not check this.
REQ-005 IDLE: channel SHALL examine requesters with req_valid=1 and req_dest matching the channel; a single match wins; if both match, the requester indicated by the channel's round-robin pointer wins.
REQ-006 On a win, the channel SHALL latch owner, product and clamped number at the clock edge and move to WAIT.
REQ-007 The quantity clamp SHALL map req_number>50 to 50; other values pass unchanged.
REQ-008 A latched quantity of 0 SHALL skip the transfer: next state IDLE, req_ack pulse to owner, no valid strobe, pointer advances.
REQ-009 WAIT: when ready_x=1 the channel SHALL go to SEND; otherwise it remains in WAIT.
REQ-010 SEND (exactly one cycle): valid_x=1, product_x/number_x = latched values, req_ack[owner]=1; pointer := other requester; next state IDLE.
REQ-011 Outside SEND, valid_x SHALL be 0 and product_x/number_x SHALL be 0.
REQ-012 Minimum latency: request visible in cycle t with ready already high -> valid_x and req_ack in cycle t+2.
REQ-013 A channel in IDLE during the cycle after SEND SHALL re-arbitrate on that cycle's inputs; back-to-back grants are therefore possible every 3 cycles.
REQ-014 Both channels SHALL be able to be in SEND in the same cycle (two ack bits set).
REQ-015 A request whose destination channel is busy SHALL wait; it is never dropped.
REQ-016 busy_x SHALL be 1 in WAIT and SEND, 0 in IDLE.

Reset
REQ-017 On rst: both FSMs -> IDLE; both pointers -> requester 0; all outputs 0; latched fields 0; timeout counters 0.
REQ-018 rst asserted mid-WAIT or mid-SEND SHALL abort without ack, err or valid; the requester must re-present its request.

Configuration
REQ-019 Macro RESTOCK_ARB_TIMEOUT_EN defined: each channel SHALL have a 4-bit WAIT counter, cleared on entering WAIT. After 15 consecutive WAIT cycles with ready_x=0, the channel SHALL go to IDLE, pulse req_err[owner] (no ack, no valid) and advance the pointer.
REQ-020 Macro undefined: WAIT SHALL persist indefinitely; req_err SHALL be tied 0; port list is unchanged.

Verification
REQ-021 Req0 kitchen, product=1, number=20; ready_kitch=1 -> valid_kitch, product_kitch=1, number_kitch=20, req_ack=2'b01 in cycle t+2.
REQ-022 Req0 and req1 both refrigerator, ready_refri=1 from reset -> req0 served first, then req1 (pointer rotation); the next contention is won by req0 again.
REQ-023 Req0 kitchen number=63, req1 refrigerator number=0 -> number_kitch=50 with ack0; ack1 with valid_refri never high.
REQ-024 Req0 kitchen, ready_kitch low 5 cycles then high -> busy_kitch=1 throughout; single valid_kitch pulse one cycle after ready rises.
REQ-025 With RESTOCK_ARB_TIMEOUT_EN, ready_refri held 0 -> req_err=2'b10 for refrigerator owner req1 after 15 WAIT cycles, busy_refri=0 next cycle; without the macro, busy_refri stays 1.
REQ-026 rst pulse while kitchen in WAIT -> all outputs 0 immediately, no ack; the re-issued request completes normally.
